// File: rtl/sys_pio_in_edge.sv
// sys_pio_in_edge
// ----------------
// Memory-mapped input PIO with per-bit edge capture and a level interrupt.
// External inputs are synchronised into the clk domain. Each bit can latch a
// rising, falling or any transition into EDGECAPTURE. The capture bits are
// ANDed with IRQMASK to produce a registered, active-high level irq.
//
// Register map (word address):
//   0 DATA        read-only, synchronised input (writes ignored)
//   1 reserved    reads 0, writes ignored
//   2 IRQMASK     read/write, bits [WIDTH-1:0]
//   3 EDGECAPTURE read, write-1-to-clear per bit
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high reset
//   address     word address of the register
//   chipselect  slave select, qualifies write
//   write       write strobe
//   writedata   write data
//   readdata    registered read data (1-cycle latency, bits above WIDTH read 0)
//   in_port     asynchronous external inputs
//   irq         level interrupt request, active-high
//
// Bus handshake: the slave has no wait states and no ready signal. A write
// takes effect on the clock edge where chipselect and write are both 1.
// readdata is refreshed on every edge from the currently addressed register,
// whether or not chipselect is asserted. The value returned is the register
// content before any write in that same cycle.

module sys_pio_in_edge #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Wide enough for SYNC_STAGES+1 with SYNC_STAGES up to 4.
  localparam int GUARD_W = 3;

  logic [WIDTH-1:0]   sync_r [SYNC_STAGES];
  logic [WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]   prev_q;
  logic [GUARD_W-1:0] guard_cnt;
  logic [WIDTH-1:0]   edgecapture;
  logic [WIDTH-1:0]   irqmask;

  logic               wr_en;
  logic [WIDTH-1:0]   edge_raw;
  logic [WIDTH-1:0]   edge_det;
  logic [WIDTH-1:0]   clr_bits;
  logic [WIDTH-1:0]   cap_next;
  logic [WIDTH-1:0]   mask_next;
  logic [31:0]        rd_mux;

  assign sync_q = sync_r[SYNC_STAGES-1];
  assign wr_en  = chipselect & write;

  // Input synchroniser: stage 0 samples the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Startup guard. The synchroniser and prev_q come out of reset at 0. Pins
  // that are already high would otherwise look like a rising edge. The guard
  // counts down until the synchroniser and prev_q hold real pin values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      guard_cnt <= GUARD_W'(SYNC_STAGES + 1);
    end else begin
      prev_q <= sync_q;
      if (guard_cnt != '0) guard_cnt <= guard_cnt - 1'b1;
    end
  end

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = sync_q & ~prev_q;
      1:       edge_raw = ~sync_q & prev_q;
      default: edge_raw = sync_q ^ prev_q;
    endcase
    edge_det = (guard_cnt == '0) ? edge_raw : '0;
  end

  // Next-state for capture and mask. A new edge wins over a simultaneous
  // write-1-to-clear of the same bit, so no transition is lost.
  always_comb begin
    clr_bits  = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    cap_next  = (edgecapture & ~clr_bits) | edge_det;
    mask_next = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync_q;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edgecapture <= '0;
      irqmask     <= RESET_MASK;
      irq         <= 1'b0;
      readdata    <= '0;
    end else begin
      edgecapture <= cap_next;
      irqmask     <= mask_next;
      // Built from next-state so irq follows capture/mask with no extra lag.
      irq         <= |(cap_next & mask_next);
      readdata    <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sys_pio_in_edge.sv
// Bench for sys_pio_in_edge. Three instances share one bus:
//   0: WIDTH=32, SYNC_STAGES=2, rising edges,  RESET_MASK=0
//   1: WIDTH=8,  SYNC_STAGES=3, falling edges, RESET_MASK=8'hA5
//   2: WIDTH=8,  SYNC_STAGES=2, any edge,      RESET_MASK=0
// A reference model of each instance runs one step per clock. Its readdata and
// irq predictions are compared every cycle. Directed checks cover the
// startup, latency, capture, masking, set/clear and reset scenarios.

module tb_sys_pio_in_edge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] in_v  [3];
  logic [31:0] rd_o  [3];
  logic        irq_o [3];

  sys_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(32'h0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_o[0]),
    .in_port(in_v[0]), .irq(irq_o[0]));

  sys_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(1), .RESET_MASK(8'hA5)) u_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_o[1]),
    .in_port(in_v[1][7:0]), .irq(irq_o[1]));

  sys_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_MASK(8'h00)) u_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(rd_o[2]),
    .in_port(in_v[2][7:0]), .irq(irq_o[2]));

  // ---------------- per-instance configuration ----------------
  function automatic int p_stages(int k);
    return (k == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] p_wmask(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] p_rmask(int k);
    return (k == 1) ? 32'h0000_00A5 : 32'h0;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_dl   [3][4];   // delay line: pin value as seen by the core after N edges
  logic [31:0] m_prev [3];
  logic [31:0] m_cap  [3];
  logic [31:0] m_mask [3];
  int          m_n    [3];      // edges since reset
  logic [31:0] exp_rd [3];
  logic        exp_irq[3];

  task automatic model_step(input int k);
    logic [31:0] wm, sync, ev, clr, ncap, nmask;
    int s;
    wm = p_wmask(k);
    s  = p_stages(k);
    if (reset) begin
      for (int i = 0; i < 4; i++) m_dl[k][i] = '0;
      m_prev[k] = '0;
      m_cap[k]  = '0;
      m_mask[k] = p_rmask(k);
      m_n[k]    = 0;
      exp_rd[k] = '0;
      exp_irq[k] = 1'b0;
    end else begin
      sync = m_dl[k][0];
      case (address)
        2'd0:    exp_rd[k] = sync;
        2'd2:    exp_rd[k] = m_mask[k];
        2'd3:    exp_rd[k] = m_cap[k];
        default: exp_rd[k] = '0;
      endcase
      ev = '0;
      if (m_n[k] >= s + 1) begin
        if (k == 0)      ev = sync & ~m_prev[k];
        else if (k == 1) ev = ~sync & m_prev[k];
        else             ev = sync ^ m_prev[k];
      end
      ev    = ev & wm;
      clr   = (chipselect && write && address == 2'd3) ? (writedata & wm) : 32'h0;
      ncap  = (m_cap[k] & ~clr) | ev;
      nmask = (chipselect && write && address == 2'd2) ? (writedata & wm) : m_mask[k];
      exp_irq[k] = |(ncap & nmask);
      m_cap[k]  = ncap;
      m_mask[k] = nmask;
      m_prev[k] = sync;
      for (int i = 0; i < s - 1; i++) m_dl[k][i] = m_dl[k][i+1];
      m_dl[k][s-1] = in_v[k] & wm;
      if (m_n[k] < 100) m_n[k]++;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are driven while clk is low; outputs are sampled 1 ns after posedge.
  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rd%0d", k), rd_o[k], exp_rd[k]);
      check($sformatf("irq%0d", k), {31'b0, irq_o[k]}, {31'b0, exp_irq[k]});
    end
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = 2'd0; writedata = '0;
    for (int k = 0; k < 3; k++) in_v[k] = 32'hFFFF_FFFF;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();

    // Startup: inputs high through reset give DATA all ones and no capture.
    address = 2'd0; tick();
    check("startup_data", rd_o[0], 32'hFFFF_FFFF);
    check("startup_irq", {31'b0, irq_o[0]}, 32'h0);
    address = 2'd3; tick();
    check("startup_cap", rd_o[0], 32'h0);

    // DATA latency: visible on readdata on the third edge after the change.
    in_v[0] = 32'h0; address = 2'd0; repeat (4) tick();
    in_v[0] = 32'hA5;
    tick(); tick();
    check("lat_t2", rd_o[0], 32'h0);
    tick();
    check("lat_t3", rd_o[0], 32'hA5);

    // Rising capture of a 1-cycle pulse, irq, then W1C.
    in_v[0] = 32'h0; repeat (3) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h1);
    in_v[0] = 32'h1; tick();
    in_v[0] = 32'h0; repeat (5) tick();
    address = 2'd3; tick();
    check("rise_cap", rd_o[0], 32'h1);
    check("rise_irq", {31'b0, irq_o[0]}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("w1c_irq", {31'b0, irq_o[0]}, 32'h0);
    tick();
    check("w1c_cap", rd_o[0], 32'h0);

    // Any-edge capture with mask off, then enabling the mask.
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_v[2] = in_v[2] ^ 32'h10;
    repeat (5) tick();
    address = 2'd3; tick();
    check("any_cap", rd_o[2], 32'h10);
    check("any_irq_masked", {31'b0, irq_o[2]}, 32'h0);
    bus_write(2'd2, 32'h10);
    check("any_irq_unmasked", {31'b0, irq_o[2]}, 32'h1);

    // Edge on bit 3 lands in the same cycle as its W1C: set wins.
    bus_write(2'd2, 32'h8);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_v[0] = 32'h8;
    tick(); tick();
    bus_write(2'd3, 32'h8);
    check("simul_irq", {31'b0, irq_o[0]}, 32'h1);
    address = 2'd3; tick();
    check("simul_cap", rd_o[0], 32'h8);

    // Narrow width masks writes; mid-operation reset.
    bus_write(2'd2, 32'hFFFF_FFFF);
    address = 2'd2; tick();
    check("width_mask", rd_o[1], 32'hFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_v[2] = ~in_v[2] & 32'hFF;
    repeat (5) tick();
    address = 2'd3; tick();
    check("pre_rst_cap", rd_o[2], 32'hFF);
    check("pre_rst_irq", {31'b0, irq_o[2]}, 32'h1);
    reset = 1'b1; tick();
    check("rst_rd", rd_o[2], 32'h0);
    check("rst_irq", {31'b0, irq_o[2]}, 32'h0);
    reset = 1'b0; address = 2'd2; tick();
    check("rst_mask_b", rd_o[1], 32'hA5);
    check("rst_mask_c", rd_o[2], 32'h0);
    address = 2'd3; tick();
    check("rst_cap_c", rd_o[2], 32'h0);

    // Randomised traffic against the model.
    repeat (1500) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 3) == 0) in_v[k] = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write      = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << $urandom_range(0, 31));
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
